// File: rtl/conv_seq_ctrl_if.sv
// Control/status bundle between the register interface (master) and the convolution sequencer (slave).
interface conv_seq_ctrl_if;
    logic [31:0] ctrl;
    logic [31:0] state;
    logic        busy;
    logic        done;
    logic [15:0] tile_idx;
    logic [31:0] perf_cnt;

    modport master (output ctrl, input state, busy, done, tile_idx, perf_cnt);
    modport slave  (input ctrl, output state, busy, done, tile_idx, perf_cnt);
endinterface

// File: rtl/conv_seq_ctrl.sv
// Convolution core sequencer: walks every channel of every tile and drives the 32-bit datapath enable vector.
// Optional busy-cycle counter is built when CONV_SEQ_CTRL_PERF_EN is defined.
module conv_seq_ctrl #(
    parameter int unsigned IFM_WORDS = 4,
    parameter int unsigned WHT_WORDS = 2,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned PE_CYC    = 9,
    parameter int unsigned P2S_WORDS = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    conv_seq_ctrl_if.slave   bus
);
    localparam int unsigned FETCH_CYC = ((IFM_WORDS > WHT_WORDS) ? IFM_WORDS : WHT_WORDS) + RD_LAT;
    localparam int unsigned CNT_MAX_A = (FETCH_CYC > PE_CYC) ? FETCH_CYC : PE_CYC;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > P2S_WORDS) ? CNT_MAX_A : P2S_WORDS;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned CH_W      = 8;
    localparam int unsigned TILE_W    = 16;
    localparam int unsigned STATE_W   = 32;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_PE, S_PA, S_BA, S_CA, S_RELU, S_P2SW, S_P2SR, S_DONE
    } fsm_e;

    fsm_e                fsm_q, fsm_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CH_W-1:0]     chnl_q, chnl_d, ch_max_q, ch_max_d;
    logic [TILE_W-1:0]   tile_q, tile_d, tile_max_q, tile_max_d;
    logic [STATE_W-1:0]  state_q, state_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                start_prev_q;
    logic                accept_c;
    logic [31:0]         ctrl;

    assign ctrl = bus.ctrl;

    logic unused_ctrl_bits;
    assign unused_ctrl_bits = ^{ctrl[31:28], ctrl[3:2]};

    // Enable vector for a given FSM position; first_ch selects load vs accumulate in the channel adder.
    function automatic logic [STATE_W-1:0] decode(fsm_e s, logic [CNT_W-1:0] c, logic first_ch);
        logic [STATE_W-1:0] v;
        v = '0;
        case (s)
            S_FETCH: begin
                v[0] = c < CNT_W'(IFM_WORDS);
                v[1] = c < CNT_W'(WHT_WORDS);
                v[4] = (c >= CNT_W'(RD_LAT)) && (c < CNT_W'(IFM_WORDS + RD_LAT));
                v[5] = (c >= CNT_W'(RD_LAT)) && (c < CNT_W'(WHT_WORDS + RD_LAT));
            end
            S_PE:    v[3:2] = 2'b11;
            S_PA:    v[7:6] = 2'b11;
            S_BA:    v[8] = 1'b1;
            S_CA:    begin v[9] = 1'b1; v[13] = first_ch; end
            S_RELU:  v[10] = 1'b1;
            S_P2SW:  v[11] = 1'b1;
            S_P2SR:  v[12] = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Next-state, counters and registered output values.
    always_comb begin
        fsm_d      = fsm_q;
        cnt_d      = cnt_q;
        chnl_d     = chnl_q;
        tile_d     = tile_q;
        ch_max_d   = ch_max_q;
        tile_max_d = tile_max_q;
        done_d     = done_q;
        accept_c   = 1'b0;

        case (fsm_q)
            S_IDLE: begin
                if (ctrl[0] && !start_prev_q && !ctrl[1]) begin
                    accept_c   = 1'b1;
                    fsm_d      = S_FETCH;
                    cnt_d      = '0;
                    chnl_d     = '0;
                    tile_d     = '0;
                    done_d     = 1'b0;
                    ch_max_d   = (ctrl[11:4] == '0) ? '0 : ctrl[11:4] - CH_W'(1);
                    tile_max_d = (ctrl[27:12] == '0) ? '0 : ctrl[27:12] - TILE_W'(1);
                end
            end
            S_FETCH: begin
                if (cnt_q == CNT_W'(FETCH_CYC - 1)) begin
                    fsm_d = S_PE;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PE: begin
                if (cnt_q == CNT_W'(PE_CYC - 1)) begin
                    fsm_d = S_PA;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PA:   fsm_d = S_BA;
            S_BA:   fsm_d = S_CA;
            S_CA: begin
                if (chnl_q < ch_max_q) begin
                    chnl_d = chnl_q + CH_W'(1);
                    fsm_d  = S_FETCH;
                    cnt_d  = '0;
                end else begin
                    fsm_d = S_RELU;
                end
            end
            S_RELU: fsm_d = S_P2SW;
            S_P2SW: begin
                fsm_d = S_P2SR;
                cnt_d = '0;
            end
            S_P2SR: begin
                if (cnt_q == CNT_W'(P2S_WORDS - 1)) begin
                    cnt_d = '0;
                    if (tile_q < tile_max_q) begin
                        tile_d = tile_q + TILE_W'(1);
                        chnl_d = '0;
                        fsm_d  = S_FETCH;
                    end else begin
                        fsm_d  = S_DONE;
                        done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  fsm_d = S_IDLE;
            default: fsm_d = S_IDLE;
        endcase

        // Abort wins over everything, including a completion in the same cycle.
        if (ctrl[1] && (fsm_q != S_IDLE)) begin
            fsm_d  = S_IDLE;
            cnt_d  = '0;
            chnl_d = '0;
            tile_d = '0;
            done_d = done_q;
        end

        state_d = decode(fsm_d, cnt_d, chnl_d == '0);
        busy_d  = (fsm_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q        <= S_IDLE;
            cnt_q        <= '0;
            chnl_q       <= '0;
            tile_q       <= '0;
            ch_max_q     <= '0;
            tile_max_q   <= '0;
            state_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            cnt_q        <= cnt_d;
            chnl_q       <= chnl_d;
            tile_q       <= tile_d;
            ch_max_q     <= ch_max_d;
            tile_max_q   <= tile_max_d;
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            start_prev_q <= ctrl[0];
        end
    end

    assign bus.state    = state_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.tile_idx = tile_q;

`ifdef CONV_SEQ_CTRL_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Saturating busy-cycle counter, restarted by each accepted start.
    always_comb begin
        perf_d = perf_q;
        if (accept_c) begin
            perf_d = '0;
        end else if (busy_q && (perf_q != '1)) begin
            perf_d = perf_q + 32'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign bus.perf_cnt = perf_q;
`else
    logic unused_accept;
    assign unused_accept = accept_c;
    assign bus.perf_cnt  = '0;
`endif
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Scoreboard bench for conv_seq_ctrl: stimulus pushes per-run expected statistics, a monitor collects and compares.
module tb_conv_seq_ctrl;
    logic clk;
    logic rst_n;

    conv_seq_ctrl_if bus ();

    conv_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef CONV_SEQ_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        int busy; int ird; int wrd; int is2p; int ws2p; int pe;
        int pa; int ba; int ca; int caf; int relu; int p2sw; int p2sr;
        int tmax; int s2p0; int done; int bad;
    } rec_t;

    rec_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: accumulate enable statistics over each busy window, then compare with the queued expectation.
    rec_t m;
    bit   in_run = 1'b0;
    always @(negedge clk) begin
        rec_t e;
        if (!rst_n) begin
            if (in_run && sb_q.size() > 0) sb_q.delete(0);
            in_run = 1'b0;
        end else if (bus.busy) begin
            if (!in_run) begin
                in_run = 1'b1;
                m = '{default: 0};
                m.s2p0 = -1;
                chk("done_clr", 64'(bus.done), 64'd0);
                chk("run_expected", 64'(sb_q.size() > 0), 64'd1);
            end
            if (bus.state[0])  m.ird++;
            if (bus.state[1])  m.wrd++;
            if (bus.state[2])  m.pe++;
            if (bus.state[4]) begin
                if (m.s2p0 < 0) m.s2p0 = m.busy;
                m.is2p++;
            end
            if (bus.state[5])  m.ws2p++;
            if (bus.state[6])  m.pa++;
            if (bus.state[8])  m.ba++;
            if (bus.state[9])  m.ca++;
            if (bus.state[13]) m.caf++;
            if (bus.state[10]) m.relu++;
            if (bus.state[11]) m.p2sw++;
            if (bus.state[12]) m.p2sr++;
            if ((bus.state[3] != bus.state[2]) || (bus.state[7] != bus.state[6]) ||
                (bus.state[13] && !bus.state[9]) || (bus.state[31:14] != '0)) m.bad++;
            if (int'(bus.tile_idx) > m.tmax) m.tmax = int'(bus.tile_idx);
            m.busy++;
        end else if (in_run) begin
            in_run = 1'b0;
            chk("idle_state", 64'(bus.state), 64'd0);
            chk("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("busy_cycles", 64'(m.busy), 64'(e.busy));
                chk("ifm_rd",      64'(m.ird),  64'(e.ird));
                chk("wht_rd",      64'(m.wrd),  64'(e.wrd));
                chk("ifm_s2p",     64'(m.is2p), 64'(e.is2p));
                chk("wht_s2p",     64'(m.ws2p), 64'(e.ws2p));
                chk("ifm_s2p_f",   64'(m.s2p0), 64'(e.s2p0));
                chk("pe",          64'(m.pe),   64'(e.pe));
                chk("pa",          64'(m.pa),   64'(e.pa));
                chk("ba",          64'(m.ba),   64'(e.ba));
                chk("ca",          64'(m.ca),   64'(e.ca));
                chk("ca_first",    64'(m.caf),  64'(e.caf));
                chk("relu",        64'(m.relu), 64'(e.relu));
                chk("p2sw",        64'(m.p2sw), 64'(e.p2sw));
                chk("p2sr",        64'(m.p2sr), 64'(e.p2sr));
                chk("tile_max",    64'(m.tmax), 64'(e.tmax));
                chk("bit_rules",   64'(m.bad),  64'(e.bad));
                chk("done",        64'(bus.done), 64'(e.done));
                chk("perf_cnt",    64'(bus.perf_cnt), PERF ? 64'(e.busy) : 64'd0);
            end
        end
    end

    function automatic logic [31:0] cfg(input logic [7:0] ch, input logic [15:0] tl);
        return {4'b0, tl, ch, 4'b0};
    endfunction

    // Start a run and wait (bounded) for busy to drop; hold keeps the start bit high afterwards.
    task automatic do_run(input logic [7:0] ch, input logic [15:0] tl, input rec_t e, input bit hold);
        int n;
        sb_q.push_back(e);
        @(negedge clk) bus.ctrl = cfg(ch, tl) | 32'd1;
        @(negedge clk) if (!hold) bus.ctrl[0] = 1'b0;
        n = 0;
        while (bus.busy && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 6000) chk("run_timeout", 64'(n), 64'd0);
        if (hold) begin
            repeat (8) @(negedge clk);
            bus.ctrl[0] = 1'b0;
        end
        @(negedge clk);
    endtask

    //                  busy ird wrd is2p ws2p  pe   pa  ba  ca caf rl p2w p2r tm s0 dn bad
    localparam rec_t R11   = '{  29,   4,  2,   4,   2,   9,   1,  1,  1, 1, 1, 1,  9, 0, 1, 1, 0};
    localparam rec_t R31   = '{  63,  12,  6,  12,   6,  27,   3,  3,  3, 1, 1, 1,  9, 0, 1, 1, 0};
    localparam rec_t R22   = '{  91,  16,  8,  16,   8,  36,   4,  4,  4, 2, 2, 2, 18, 1, 1, 1, 0};
    localparam rec_t R2551 = '{4347,1020,510,1020, 510,2295, 255,255,255, 1, 1, 1,  9, 0, 1, 1, 0};
    localparam rec_t RABT  = '{   8,   4,  2,   4,   2,   3,   0,  0,  0, 0, 0, 0,  0, 0, 1, 0, 0};
    localparam rec_t RDUMMY = '{default: 0};

    initial begin
        bus.ctrl = '0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state",    64'(bus.state),    64'd0);
        chk("rst_busy",     64'(bus.busy),     64'd0);
        chk("rst_done",     64'(bus.done),     64'd0);
        chk("rst_tile_idx", 64'(bus.tile_idx), 64'd0);
        chk("rst_perf",     64'(bus.perf_cnt), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_run(8'd1,   16'd1, R11,   1'b0);
        do_run(8'd3,   16'd1, R31,   1'b0);
        do_run(8'd2,   16'd2, R22,   1'b0);
        do_run(8'd255, 16'd1, R2551, 1'b0);
        do_run(8'd0,   16'd0, R11,   1'b1);

        // Abort on the third PE cycle with a start edge issued while busy.
        sb_q.push_back(RABT);
        @(negedge clk) bus.ctrl = cfg(8'd1, 16'd1) | 32'd1;
        @(negedge clk) bus.ctrl[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) bus.ctrl[0] = 1'b1;
            if (i == 7) bus.ctrl[1] = 1'b1;
            @(negedge clk);
        end
        chk("abort_busy",  64'(bus.busy),  64'd0);
        chk("abort_state", 64'(bus.state), 64'd0);
        chk("abort_done",  64'(bus.done),  64'd0);
        bus.ctrl[1] = 1'b0;
        repeat (6) @(negedge clk);
        chk("no_restart", 64'(bus.busy), 64'd0);
        bus.ctrl = '0;
        @(negedge clk);
        do_run(8'd1, 16'd1, R11, 1'b0);

        // Asynchronous reset in the middle of PE.
        sb_q.push_back(RDUMMY);
        @(negedge clk) bus.ctrl = cfg(8'd1, 16'd1) | 32'd1;
        @(negedge clk) bus.ctrl[0] = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state",    64'(bus.state),    64'd0);
        chk("arst_busy",     64'(bus.busy),     64'd0);
        chk("arst_done",     64'(bus.done),     64'd0);
        chk("arst_tile_idx", 64'(bus.tile_idx), 64'd0);
        chk("arst_perf",     64'(bus.perf_cnt), 64'd0);
        @(negedge clk) bus.ctrl = '0;
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_busy",  64'(bus.busy),  64'd0);
        chk("post_rst_state", 64'(bus.state), 64'd0);
        do_run(8'd1, 16'd1, R11, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
